output_score_packer: RTL
========================

// Module: output_score_packer
// PURPOSE
//  Serial-to-parallel collector at the output layer. Accepts one 8-bit class score per beat
//  from the output neuron over a valid/ready stream. Packs N_CLASSES scores into one flat vector.
//  Presents the vector with out_valid, which drives the enable of the argmax classifier.
//  Holds the vector stable until the consumer accepts it.
// PARAMETERS
//  SCORE_W    8   width of one class score, unsigned
//  N_CLASSES  10  scores per frame; output vector is N_CLASSES*SCORE_W = 80 bits
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst        in   1                  synchronous, active-high reset
//  in_valid   in   1                  in_data/in_last valid this cycle
//  in_ready   out  1                  packer can accept a score this cycle
//  in_data    in   SCORE_W            score of class k (k = beat index within frame)
//  in_last    in   1                  marks final score of a frame
//  out_valid  out  1                  out_vec holds a complete frame (-> classifier enable)
//  out_ready  in   1                  consumer accepts out_vec this cycle
//  out_vec    out  N_CLASSES*SCORE_W  score k at bits [SCORE_W*k +: SCORE_W]
//  frame_err  out  1                  one-cycle pulse on framing error
// BEHAVIOUR
//  - Reset values: state=COLLECT, cnt=0, out_vec=0, out_valid=0, frame_err=0.
//    in_ready is forced 0 while rst=1.
//  - States: COLLECT (in_ready=1, out_valid=0); HOLD (in_ready=0, out_valid=1).
//  - Beat = in_valid & in_ready. On a beat, in_data is written to slot cnt and cnt increments.
//    cnt range is 0..N_CLASSES-1 and its width is clog2(N_CLASSES).
//  - Frame close: a beat at cnt==N_CLASSES-1 enters HOLD on the next edge.
//    out_valid rises the cycle after the 10th beat (latency 1). cnt returns to 0.
//  - A missing in_last on the closing beat still completes and delivers the frame.
//    frame_err pulses in the same cycle out_valid rises.
//  - Early last: a beat with in_last=1 and cnt<N_CLASSES-1 discards the partial frame.
//    cnt goes to 0 and frame_err pulses the next cycle. No out_valid; stay in COLLECT.
//  - HOLD: out_vec and out_valid are stable while out_ready=0. in_valid is ignored
//    (no beat occurs; upstream keeps its data).
//  - out_valid & out_ready -> COLLECT next edge. in_ready=1 the following cycle.
//    No overlap between HOLD and collection; minimum frame period is N_CLASSES+1 cycles.
//  - out_vec is only updated slot-by-slot during COLLECT. Unwritten slots keep the
//    previous frame's data until overwritten. A frame is valid only at out_valid.
//  - in_valid gaps between beats are allowed with no timing limit.
//  - rst mid-frame or mid-HOLD: returns to reset values on the next edge. The partial or
//    held frame is lost and no frame_err is raised.
//  - No arithmetic on scores; pure storage. Tie-breaking belongs to the classifier.
// STRUCTURE
//  - Shared package fnn_pkg: SCORE_W=8, N_CLASSES=10, CLASS_IDX_W=4, state enum
//    {COLLECT, HOLD}. The classifier uses the same constants.
//  - Single module. The FSM, beat counter and slot write-enable decode are in one
//    clocked process, and no sub-module is warranted.
//  - out_vec is a register array of N_CLASSES x SCORE_W, written by one-hot slot enable.
// TESTING
//  1. Hold rst 3 cycles -> out_valid=0, out_vec=0, frame_err=0, in_ready=0.
//     Release rst -> in_ready=1 the next cycle.
//  2. Stream 9,7,6,15,13,17,20,7,1,2 back-to-back, last on beat 10, out_ready=1.
//     -> out_vec={2,1,7,20,17,13,15,6,7,9} (MSB slot first), out_valid high for 1 cycle,
//     the cycle after beat 10. Downstream classifier reports index 6.
//  3. Same frame with out_ready=0 for 5 cycles and in_valid=1 -> out_valid held,
//     out_vec stable, in_ready=0, no beats accepted. Accept on cycle 6 -> in_ready=1 next cycle.
//  4. in_last on beat 4 -> frame_err pulses 1 cycle, no out_valid. The next 10 beats
//     (values 10..19) produce out_vec slot k = 10+k with frame_err=0.
//  5. 10 beats with in_last=0 -> frame delivered normally, frame_err pulses with out_valid rise.
//  6. rst after 6 beats, then a clean 10-beat frame -> all slots show the new values.
//     Repeat with random in_valid gaps (0-3 cycles) -> same out_vec, out_valid latency 1.

Source files
------------

// File: rtl/fnn_pkg.sv
// fnn_pkg
// Constants and types shared by the output layer of the network: the score
// packer and the argmax classifier both size themselves from these values.
//   SCORE_W      width of one unsigned class score
//   N_CLASSES    number of class scores per frame
//   CLASS_IDX_W  width of a class index (clog2 of N_CLASSES)
//   VEC_W        width of the packed score vector
//   packer_state_e  COLLECT gathers scores, HOLD presents a finished frame
package fnn_pkg;

  localparam int SCORE_W     = 8;
  localparam int N_CLASSES   = 10;
  localparam int CLASS_IDX_W = 4;
  localparam int VEC_W       = N_CLASSES * SCORE_W;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_e;

endpackage

// File: rtl/output_score_packer.sv
// output_score_packer
// Serial-to-parallel collector at the output layer. One class score arrives
// per accepted beat; after N_CLASSES beats the whole frame is presented on
// out_vec with out_valid, which acts as the enable of the argmax classifier.
// The frame is held stable until the consumer accepts it.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data/in_last are valid this cycle
//   in_ready   packer can accept a score this cycle (0 while rst=1)
//   in_data    score of class k, k = beat index within the frame
//   in_last    marks the final score of a frame
//   out_valid  out_vec holds a complete frame
//   out_ready  consumer accepts out_vec this cycle
//   out_vec    score k at bits [SCORE_W*k +: SCORE_W]
//   frame_err  one-cycle pulse on a framing error
module output_score_packer
  import fnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VEC_W-1:0]   out_vec,
  output logic               frame_err
);

  localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(N_CLASSES - 1);

  packer_state_e          state_q;
  logic [CLASS_IDX_W-1:0] cnt_q;
  logic [SCORE_W-1:0]     slot_q [N_CLASSES];
  logic                   outValid_q;
  logic                   frameErr_q;
  logic                   beat;

  // Collection and presentation never overlap, so readiness is simply the
  // COLLECT state; reset masks it so nothing is accepted while rst is high.
  assign in_ready = (state_q == COLLECT) && !rst;
  assign beat     = in_valid && in_ready;

  // FSM, beat counter and one-hot slot write all live here so that the
  // frame-close decision and the last slot write happen on the same edge.
  // frame_err defaults low every cycle, which makes it a single-cycle pulse.
  // A closing beat without in_last still delivers the frame but flags it;
  // an in_last before the final slot throws the partial frame away.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      for (int k = 0; k < N_CLASSES; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (beat) begin
            for (int k = 0; k < N_CLASSES; k++) begin
              if (cnt_q == CLASS_IDX_W'(k)) begin
                slot_q[k] <= in_data;
              end
            end
            if (cnt_q == LAST_IDX) begin
              state_q    <= HOLD;
              outValid_q <= 1'b1;
              cnt_q      <= '0;
              frameErr_q <= !in_last;
            end else if (in_last) begin
              cnt_q      <= '0;
              frameErr_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CLASS_IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= COLLECT;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= COLLECT;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the slot registers into the packed vector, class 0 in the LSBs.
  always_comb begin
    out_vec = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      out_vec[SCORE_W*k +: SCORE_W] = slot_q[k];
    end
  end

  assign out_valid = outValid_q;
  assign frame_err = frameErr_q;

endmodule
